// File: rtl/mmio_bus_ctrl.sv
// rtl/mmio_bus_ctrl.sv - CPU memory-port decoder for RAM, output registers, input ports and capture status
module mmio_bus_ctrl #(
    parameter int                ADDR_W    = 9,
    parameter int                DATA_W    = 16,
    parameter int                N_OUT     = 2,
    parameter int                N_IN      = 2,
    parameter logic [ADDR_W-1:0] OUT_BASE  = 9'h100,
    parameter logic [ADDR_W-1:0] IN_BASE   = 9'h140,
    parameter logic [ADDR_W-1:0] STAT_ADDR = 9'h180
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mem_cmd,
    input  logic [ADDR_W-1:0]       mem_addr,
    input  logic [DATA_W-1:0]       write_data,
    output logic [DATA_W-1:0]       read_data,
    output logic                    rd_valid,
    output logic                    bus_err,
    output logic [ADDR_W-2:0]       ram_addr,
    output logic                    ram_write,
    input  logic [DATA_W-1:0]       ram_dout,
    output logic [N_OUT*DATA_W-1:0] out_q,
    input  logic [N_IN*DATA_W-1:0]  in_raw
);

    localparam int AW1 = ADDR_W + 1;
    // Region bounds are widened by one bit so BASE+N never wraps.
    localparam logic [ADDR_W:0] OUT_LO = {1'b0, OUT_BASE};
    localparam logic [ADDR_W:0] OUT_HI = OUT_LO + AW1'(N_OUT);
    localparam logic [ADDR_W:0] IN_LO  = {1'b0, IN_BASE};
    localparam logic [ADDR_W:0] IN_HI  = IN_LO + AW1'(N_IN);

    logic                    cmd_rd, cmd_wr, cmd_act;
    logic                    hit_ram, hit_out, hit_in, hit_stat, hit_unm;
    logic [ADDR_W:0]         addr_x;
    logic [ADDR_W-1:0]       out_off, in_off;

    logic [N_OUT*DATA_W-1:0] out_regs_q, out_regs_d;
    logic [N_IN*DATA_W-1:0]  sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [N_IN-1:0]         cap_q, cap_d, cap_set, cap_clr;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_ram_q, rd_ram_d;
    logic [DATA_W-1:0]       rd_data_q, rd_data_d;
    logic [DATA_W-1:0]       hold_q, hold_d;
    logic                    bus_err_q, bus_err_d;

    // Address decode; a region is only hit while a read or write is in flight.
    always_comb begin
        cmd_rd   = (mem_cmd == 2'b01);
        cmd_wr   = (mem_cmd == 2'b10);
        cmd_act  = cmd_rd | cmd_wr;
        addr_x   = {1'b0, mem_addr};
        out_off  = mem_addr - OUT_BASE;
        in_off   = mem_addr - IN_BASE;
        hit_ram  = cmd_act && !mem_addr[ADDR_W-1];
        hit_out  = cmd_act && mem_addr[ADDR_W-1] && (addr_x >= OUT_LO) && (addr_x < OUT_HI);
        hit_in   = cmd_act && mem_addr[ADDR_W-1] && !hit_out
                   && (addr_x >= IN_LO) && (addr_x < IN_HI);
        hit_stat = cmd_act && mem_addr[ADDR_W-1] && !hit_out && !hit_in
                   && (mem_addr == STAT_ADDR);
        hit_unm  = cmd_act && mem_addr[ADDR_W-1] && !hit_out && !hit_in && !hit_stat;
    end

    // Output register writes.
    always_comb begin
        out_regs_d = out_regs_q;
        if (cmd_wr && hit_out) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (out_off == ADDR_W'(i)) begin
                    out_regs_d[i*DATA_W +: DATA_W] = write_data;
                end
            end
        end
    end

    // Two-flop synchroniser, edge history and capture flags; a new edge beats a clear.
    always_comb begin
        sync1_d = in_raw;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        cap_set = '0;
        for (int i = 0; i < N_IN; i++) begin
            cap_set[i] = (sync2_q[i*DATA_W +: DATA_W] != prev_q[i*DATA_W +: DATA_W]);
        end
        cap_clr = '0;
        if (hit_stat && cmd_rd) begin
            cap_clr = cap_q;
        end else if (hit_stat && cmd_wr) begin
            cap_clr = write_data[N_IN-1:0];
        end
        cap_d = (cap_q & ~cap_clr) | cap_set;
    end

    // Read request stage: latch source select and non-RAM data for the next cycle.
    always_comb begin
        rd_valid_d = cmd_rd;
        rd_ram_d   = cmd_rd && hit_ram;
        rd_data_d  = rd_data_q;
        bus_err_d  = bus_err_q | hit_unm;
        if (cmd_rd) begin
            rd_data_d = '0;
            if (hit_out) begin
                for (int i = 0; i < N_OUT; i++) begin
                    if (out_off == ADDR_W'(i)) begin
                        rd_data_d = out_regs_q[i*DATA_W +: DATA_W];
                    end
                end
            end else if (hit_in) begin
                for (int i = 0; i < N_IN; i++) begin
                    if (in_off == ADDR_W'(i)) begin
                        rd_data_d = sync2_q[i*DATA_W +: DATA_W];
                    end
                end
            end else if (hit_stat) begin
                rd_data_d[N_IN-1:0] = cap_q;
            end
        end
    end

    // Read return mux; RAM data arrives a cycle late so it is picked here, and the
    // last returned word is held so read_data is stable between strobes.
    always_comb begin
        if (rd_valid_q) begin
            read_data = rd_ram_q ? ram_dout : rd_data_q;
        end else begin
            read_data = hold_q;
        end
        hold_d = read_data;
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_regs_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            cap_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_ram_q   <= 1'b0;
            rd_data_q  <= '0;
            hold_q     <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            out_regs_q <= out_regs_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            cap_q      <= cap_d;
            rd_valid_q <= rd_valid_d;
            rd_ram_q   <= rd_ram_d;
            rd_data_q  <= rd_data_d;
            hold_q     <= hold_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign bus_err   = bus_err_q;
    assign out_q     = out_regs_q;
    assign ram_addr  = mem_addr[ADDR_W-2:0];
    assign ram_write = cmd_wr && hit_ram;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// tb/tb_mmio_bus_ctrl.sv - self-checking bench for mmio_bus_ctrl
module tb_mmio_bus_ctrl;

    localparam int NO = 2;
    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mem_cmd = 2'b00;
    logic [8:0]  mem_addr = '0;
    logic [15:0] write_data = '0;
    logic [15:0] read_data;
    logic        rd_valid;
    logic        bus_err;
    logic [7:0]  ram_addr;
    logic        ram_write;
    logic [15:0] ram_dout = '0;
    logic [31:0] out_q;
    logic [31:0] in_raw = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mmio_bus_ctrl #(
        .ADDR_W(9), .DATA_W(16), .N_OUT(NO), .N_IN(NI),
        .OUT_BASE(9'h100), .IN_BASE(9'h140), .STAT_ADDR(9'h180)
    ) dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .read_data(read_data), .rd_valid(rd_valid),
        .bus_err(bus_err), .ram_addr(ram_addr), .ram_write(ram_write),
        .ram_dout(ram_dout), .out_q(out_q), .in_raw(in_raw)
    );

    // Board RAM: synchronous read, written by the controller's strobe.
    logic [15:0] ram_mem [256] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_addr] <= write_data;
        ram_dout <= ram_mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model. sync during cycle c is the in_raw value of cycle c-2;
    // a capture bit sets at the end of cycle c when that value differs from cycle c-3.
    logic [15:0] m_out [NO] = '{default: 16'h0};
    logic [NI-1:0] m_cap = '0;
    logic        m_err = 1'b0;
    logic        m_valid = 1'b0;
    logic [15:0] m_rdata = '0;
    logic [31:0] raw_at [8] = '{default: 32'h0};
    int          cyc = 8;
    int          ma;
    logic [15:0] m_resp;
    logic [NI-1:0] m_clr, m_set;
    logic [31:0] s_now, s_prev;
    logic        m_rd, m_wr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NO; i++) m_out[i] = '0;
            for (int i = 0; i < 8; i++) raw_at[i] = '0;
            m_cap = '0; m_err = 1'b0; m_valid = 1'b0; m_rdata = '0;
        end else begin
            raw_at[cyc % 8] = in_raw;
            s_now  = raw_at[(cyc - 2) % 8];
            s_prev = raw_at[(cyc - 3) % 8];
            for (int i = 0; i < NI; i++) m_set[i] = (s_now[i*16 +: 16] != s_prev[i*16 +: 16]);
            m_clr  = '0;
            m_resp = '0;
            m_rd   = (mem_cmd == 2'b01);
            m_wr   = (mem_cmd == 2'b10);
            ma     = int'(mem_addr);
            if (m_rd || m_wr) begin
                if (ma < 'h100) begin
                    m_resp = ram_mem[ma];
                end else if (ma >= 'h100 && ma < 'h100 + NO) begin
                    m_resp = m_out[ma - 'h100];
                    if (m_wr) m_out[ma - 'h100] = write_data;
                end else if (ma >= 'h140 && ma < 'h140 + NI) begin
                    m_resp = s_now[(ma - 'h140)*16 +: 16];
                end else if (ma == 'h180) begin
                    m_resp = 16'(m_cap);
                    m_clr  = m_rd ? m_cap : write_data[NI-1:0];
                end else begin
                    m_err = 1'b1;
                end
            end
            m_cap   = (m_cap & ~m_clr) | m_set;
            m_valid = m_rd;
            if (m_rd) m_rdata = m_resp;
            cyc++;
        end
    end

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        check("out_q", out_q, {m_out[1], m_out[0]});
        check("rd_valid", 32'(rd_valid), 32'(m_valid));
        check("read_data", 32'(read_data), 32'(m_rdata));
        check("bus_err", 32'(bus_err), 32'(m_err));
        check("ram_write", 32'(ram_write), 32'(mem_cmd == 2'b10 && !mem_addr[8]));
        check("ram_addr", 32'(ram_addr), 32'(mem_addr[7:0]));
    end

    task automatic do_cmd(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd = c; mem_addr = a; write_data = d;
        @(posedge clk); #1;
        mem_cmd = 2'b00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        idle(3);
        check("rst_out_q", out_q, 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        reset = 1'b1;
        idle(1);
        check("rel_out_q", out_q, 32'h0);
        check("rel_read_data", 32'(read_data), 32'h0);
        check("rel_rd_valid", 32'(rd_valid), 32'h0);
        check("rel_bus_err", 32'(bus_err), 32'h0);
        do_cmd(2'b01, 9'h180, 16'h0);
        check("rel_cap", 32'(read_data), 32'h0);

        // output write, read-back on the very next cycle
        do_cmd(2'b10, 9'h101, 16'hBEEF);
        check("out_write", out_q, 32'hBEEF_0000);
        do_cmd(2'b01, 9'h101, 16'h0);
        check("out_rd_data", 32'(read_data), 32'h0000_BEEF);
        check("out_rd_valid", 32'(rd_valid), 32'h1);
        check("model_out_rd", 32'(m_rdata), 32'h0000_BEEF);

        // RAM passthrough
        mem_cmd = 2'b10; mem_addr = 9'h005; write_data = 16'h1234;
        #1;
        check("ram_we_lit", 32'(ram_write), 32'h1);
        check("ram_addr_lit", 32'(ram_addr), 32'h05);
        @(posedge clk); #1;
        mem_cmd = 2'b00;
        do_cmd(2'b01, 9'h005, 16'h0);
        check("ram_rd", 32'(read_data), 32'h1234);

        // region edges, back-to-back reads
        do_cmd(2'b10, 9'h0FF, 16'hCAFE);
        do_cmd(2'b10, 9'h100, 16'h1111);
        do_cmd(2'b01, 9'h0FF, 16'h0);
        check("ram_top", 32'(read_data), 32'hCAFE);
        do_cmd(2'b01, 9'h100, 16'h0);
        check("out0_rd", 32'(read_data), 32'h1111);
        idle(2);
        check("hold", 32'(read_data), 32'h1111);

        // input capture on channel 1
        in_raw = 32'h00A5_0000;
        idle(3);
        do_cmd(2'b01, 9'h141, 16'h0);
        check("in1_rd", 32'(read_data), 32'h00A5);
        do_cmd(2'b01, 9'h180, 16'h0);
        check("stat_rd", 32'(read_data), 32'h0002);
        do_cmd(2'b01, 9'h180, 16'h0);
        check("stat_cleared", 32'(read_data), 32'h0000);

        // set/clear collision on channel 0
        in_raw[15:0] = 16'h0001;
        idle(1);
        in_raw[15:0] = 16'h0000;
        idle(2);
        do_cmd(2'b01, 9'h180, 16'h0);
        check("coll_rd1", 32'(read_data), 32'h0001);
        do_cmd(2'b01, 9'h180, 16'h0);
        check("coll_set_wins", 32'(read_data), 32'h0001);
        do_cmd(2'b01, 9'h180, 16'h0);
        check("coll_rd3", 32'(read_data), 32'h0000);

        // ignored IN write, write-1-to-clear on status
        do_cmd(2'b10, 9'h140, 16'hFFFF);
        check("in_wr_no_err", 32'(bus_err), 32'h0);
        in_raw[31:16] = 16'h0000;
        idle(3);
        do_cmd(2'b10, 9'h180, 16'h0002);
        do_cmd(2'b01, 9'h180, 16'h0);
        check("w1c", 32'(read_data), 32'h0000);

        // unmapped accesses
        do_cmd(2'b01, 9'h1F0, 16'h0);
        check("unm_rd_data", 32'(read_data), 32'h0);
        check("unm_rd_valid", 32'(rd_valid), 32'h1);
        check("unm_err", 32'(bus_err), 32'h1);
        do_cmd(2'b10, 9'h1F0, 16'hFFFF);
        check("unm_wr_out", out_q, 32'hBEEF_1111);
        idle(3);
        check("err_sticky", 32'(bus_err), 32'h1);

        // reset while a read strobe is pending
        do_cmd(2'b01, 9'h101, 16'h0);
        check("pre_rst_valid", 32'(rd_valid), 32'h1);
        reset = 1'b0;
        #2;
        check("mid_rst_valid", 32'(rd_valid), 32'h0);
        check("mid_rst_err", 32'(bus_err), 32'h0);
        check("mid_rst_out", out_q, 32'h0);
        @(posedge clk); #3;
        reset = 1'b1;
        idle(3);
        check("post_rst_valid", 32'(rd_valid), 32'h0);
        check("post_rst_data", 32'(read_data), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_bus_ctrl.md
# mmio_bus_ctrl

Parametrised memory-mapped I/O controller between the CPU memory port and the system's RAM and board I/O. It decodes every CPU command into a RAM, output-register, input-port or status access. It holds N_OUT writable output registers with read-back and N_IN synchronised input ports with change-capture flags. All read data returns through one registered path with a valid strobe.

## Interface
- ADDR_W, 9: CPU address width.
- DATA_W, 16: data width of the bus, every output register and every input port.
- N_OUT, 2: number of output registers, 1..32.
- N_IN, 2: number of input ports, 1..DATA_W.
- OUT_BASE, 9'h100: address of output register 0.
- IN_BASE, 9'h140: address of input port 0.
- STAT_ADDR, 9'h180: address of the status/capture register.
- clk  in  1  system clock; all state is rising-edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- mem_cmd  in  2  CPU command: 2'b00 none, 2'b01 read, 2'b10 write, 2'b11 treated as none.
- mem_addr  in  ADDR_W  CPU address.
- write_data  in  DATA_W  CPU write data.
- read_data  out  DATA_W  registered read result.
- rd_valid  out  1  one-cycle strobe marking read_data valid.
- bus_err  out  1  sticky unmapped-access flag.
- ram_addr  out  ADDR_W-1  RAM word address, equal to mem_addr[ADDR_W-2:0].
- ram_write  out  1  RAM write enable, combinational.
- ram_dout  in  DATA_W  RAM synchronous read data, valid one cycle after the address.
- out_q  out  N_OUT*DATA_W  output registers; channel i occupies bits [i*DATA_W +: DATA_W].
- in_raw  in  N_IN*DATA_W  asynchronous input ports, such as switches and keys.

## Operation
Address decode is combinational and evaluated only when mem_cmd is 01 or 10. Regions:
- **RAM:** mem_addr[ADDR_W-1]==0.
  - ram_write = (mem_cmd==10).
  - A read selects ram_dout as the source for the next cycle.
- **OUT:** OUT_BASE <= addr < OUT_BASE+N_OUT, with i = addr-OUT_BASE.
  - Write: out_q[i] <= write_data.
  - Read: returns out_q[i].
- **IN:** IN_BASE <= addr < IN_BASE+N_IN.
  - Read: returns the synchronised value sync[i].
  - Write: silently ignored, not an error.
- **STAT:** addr==STAT_ADDR.
  - Read: returns {zeros, cap[N_IN-1:0]} and clears the cap bits that were returned (clear-on-read).
  - Write: cap <= cap & ~write_data[N_IN-1:0] (write-1-to-clear).
- **Unmapped:** any other address with the MSB set.
  - Read: returns 0 and sets bus_err.
  - Write: no effect and sets bus_err.
  - bus_err clears only on reset.

Input ports:
- Each in_raw channel passes through a 2-flop synchroniser to give sync[i].
- cap[i] sets on any cycle where sync[i] differs from its previous-cycle value.
- If a set and a clear of cap[i] happen in the same cycle, the set wins.

Read pipeline:
- A read accepted in cycle T registers the source select and any non-RAM data at edge T+1.
- read_data and rd_valid are driven from this stage, so data is valid during cycle T+1.
- Back-to-back reads on consecutive cycles are supported at one read per cycle.
- read_data holds its last value when rd_valid=0.

## Timing
- **Reset values:** read_data=0, rd_valid=0, bus_err=0, out_q=0, cap=0, synchroniser flops=0. ram_write follows mem_cmd combinationally and is 0 while mem_cmd=00.
- **Write latency:** out_q updates at the edge ending the write cycle, so it is visible in cycle T+1.
- **Read latency:** exactly 1 cycle for every region; rd_valid pulses once per read.
- **Input-to-cap latency:** 3 edges from an in_raw change to cap=1; sync changes after 2 edges.
- **Write then read of the same OUT address in consecutive cycles:** the read returns the new value.
- **Reset mid-read:** the pending rd_valid is dropped and no strobe appears after reset releases.

## Test plan
- **Reset release:** after reset, out_q=0, read_data=0, rd_valid=0, bus_err=0, cap=0.
- **Output write and read-back:** write 16'hBEEF to 9'h101, then read 9'h101 -> out_q[31:16]=16'hBEEF; the next cycle shows read_data=16'hBEEF with rd_valid=1. out_q[15:0] stays 0.
- **RAM passthrough:**
  - Write 16'h1234 to 9'h005 -> ram_write=1, ram_addr=8'h05.
  - Read 9'h005 with the model RAM returning 16'h1234 -> read_data=16'h1234 one cycle later.
- **Input capture:**
  - Change in_raw channel 1 from 0 to 16'h00A5 -> after 3 edges cap=2'b10.
  - Read 9'h141 -> 16'h00A5.
  - Read STAT_ADDR -> 16'h0002, then re-read -> 16'h0000.
- **Set/clear collision:** toggle channel 0 so its capture lands in the same cycle as a STAT read -> cap[0] remains 1 afterwards.
- **Unmapped access:**
  - Read 9'h1F0 -> read_data=0, rd_valid=1, bus_err=1.
  - A following write to 9'h1F0 changes no out_q; bus_err stays 1 until reset.
